risc_processor: RTL and testbench
=================================

# risc_processor

Five-stage pipelined 32-bit RISC core (IF, ID, EX, MEM, WB) with an internal unified instruction/data memory and a 32-entry register file. It is the top-level compute block and has no external bus. Programs and data are preloaded into the internal arrays by the bench. Execution starts from PC 0 after reset and stops at the first HLT instruction.

## Interface
- No parameters. Memory depth is fixed at 1024 words and the register file at 32 words, both 32-bit.
- `clk  in  1  single system clock; all state updates on rising edge`
- `rst  in  1  asynchronous, active-high reset`
- Hierarchically accessible state, with fixed names for bench preload and inspection: `mem[0:1023]`, `regfile[0:31]`, `PC`, `HALTED`, `TAKEN_BRANCH`.

## Operation
- Encoding:
  - opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], sign-extended.
- RR ops (rd = rs op rt):
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed compare, result 1 or 0.
  - MUL 000101: low 32 bits of the product.
- RI ops (rt = rs op imm):
  - ADDI 001010, SUBI 001011, SLTI 001100 (signed).
- LW 001000: rt = mem[rs+imm].
- SW 001001: mem[rs+imm] = rt.
- BNEQZ 001101: branch if rs != 0. BEQZ 001110: branch if rs == 0.
  - Target = PC_of_branch + 1 + imm.
- HLT 111111.
- Any other opcode executes as a NOP (no register or memory write).
- Addressing:
  - Memory is word-addressed; only the low 10 bits of an address are used.
  - PC increments by 1 per fetch.
- Register R0:
  - Reads of R0 always return 0.
  - Writes to R0 are discarded.
- Memory access:
  - Reads are asynchronous (combinational).
  - Writes are synchronous, in the MEM stage.
- Register file writes happen in WB.
- Operand forwarding, applied at ID operand capture. The newest matching source wins:
  - first, the instruction in MEM: its ALU result, or for LW the combinational memory read data;
  - then, the instruction in WB: its write-back value;
  - otherwise, the register file.
  - Forwarding applies only to producers that write rd or rt.
- No forwarding from EX and no interlocks:
  - A consumer must issue at least 2 slots after its producer.
  - Software guarantees this with one independent or dummy instruction between them.
- Branches:
  - Resolved in EX using the forwarded rs value.
  - If taken: PC is loaded with the target, the two younger instructions (in IF/ID and ID/EX) are squashed to NOPs, and `TAKEN_BRANCH` is 1 for that cycle.
- HLT:
  - Once IF fetches HLT, fetch stops: PC holds and NOPs are injected.
  - Older instructions drain normally.
  - `HALTED` goes to 1 when HLT reaches WB and stays 1 until reset.
- Reset:
  - `PC` = 0, `HALTED` = 0, `TAKEN_BRANCH` = 0.
  - All pipeline registers become NOPs.
  - `mem` and `regfile` are NOT cleared.

## Timing
- Instruction fetched at edge n executes: ID at n+1, EX at n+2, MEM write at n+3, register write at n+4.
- After reset release, the instruction at PC = k, with no prior branch, is fetched at edge k+1.
- Throughput: one instruction per clock when no branch is taken.
- Taken-branch penalty: 2 cycles.
- Asserting `rst` mid-execution aborts all in-flight instructions immediately:
  - no further register or memory writes occur;
  - memory and register contents written before the reset are kept.
- On a MEM-stage store and a same-address LW forward in the same cycle, the load sees the old memory value, since the write happens at the clock edge.

## Test plan
- Preload `regfile[k]` = k and `mem[120]` = 85. Program:
  - `mem[0..7]` = 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000.
  - Release reset.
  - Required: `mem[121]` = 130 by edge 10; R1 = 120, R2 = 130; `HALTED` = 1 at edge 12; `mem[120]` = 85 unchanged.
- RR/RI ALU checks:
  - R1 = 7, R2 = 3 gives ADD 10, SUB 4, AND 3, OR 7, MUL 21, SLT 0.
  - SUBI R1,R1,10 gives −3 (FFFFFFFD).
  - SLTI of −3 against 0 gives 1.
- Loop with BNEQZ computing 5! in R3:
  - Required R3 = 120.
  - `TAKEN_BRANCH` pulses once per taken iteration.
  - The two instructions after a taken branch never write.
- R0 protection: ADDI R0,R0,5, then ADD R4,R0,R0 after one dummy instruction gives R4 = 0.
- Reset mid-run: assert `rst` while a SW is in ID.
  - Required: that memory location is unchanged, `PC` = 0 and `HALTED` = 0 immediately after assertion.
  - The program reruns correctly after release.
- Halt drain: HLT followed by ADDI R5,R0,1.
  - Required: R5 unchanged, `PC` frozen, no further writes.

Source files
------------

// File: rtl/risc_processor.sv
// Five-stage pipelined 32-bit RISC core (IF/ID/EX/MEM/WB) with unified word-addressed memory.
// Operands are forwarded at ID capture from the MEM and WB stages; branches resolve in EX.
module risc_processor (
  input logic clk,
  input logic rst
);
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;
  localparam logic [31:0] NOP_IR  = 32'hF800_0000;

  logic [31:0] mem     [0:1023];
  logic [31:0] regfile [0:31];
  logic [9:0]  PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  logic        fetch_stop_q, fetch_stop_d;
  logic [9:0]  pc_d;
  logic [31:0] if_id_ir_q, if_id_ir_d;
  logic [9:0]  if_id_npc_q, if_id_npc_d;
  logic [31:0] id_ex_ir_q, id_ex_ir_d;
  logic [9:0]  id_ex_npc_q, id_ex_npc_d;
  logic [31:0] id_ex_a_q, id_ex_a_d, id_ex_b_q, id_ex_b_d;
  logic [31:0] ex_mem_ir_q, ex_mem_alu_q, ex_mem_alu_d, ex_mem_b_q;
  logic [31:0] mem_wb_ir_q, mem_wb_val_q;

  // Destination register of an instruction; 0 means it writes nothing.
  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: d = ir[15:11];
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW:              d = ir[20:16];
      default:                                       d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [4:0] mem_dst,
                                          input logic [31:0] mem_val, input logic [4:0] wb_dst,
                                          input logic [31:0] wb_val, input logic [31:0] rf_val);
    if (r == 5'd0) return 32'd0;
    if (r == mem_dst) return mem_val;
    if (r == wb_dst) return wb_val;
    return rf_val;
  endfunction

  logic [31:0] fetch_ir, mem_rdata, mem_stage_val, imm_ex;
  logic [4:0]  id_rs, id_rt, mem_dst, wb_dst;
  logic [5:0]  ex_op;
  logic        unused_ok;

  assign fetch_ir      = mem[PC];
  assign mem_rdata     = mem[ex_mem_alu_q[9:0]];
  assign mem_stage_val = (ex_mem_ir_q[31:26] == OP_LW) ? mem_rdata : ex_mem_alu_q;
  assign id_rs         = if_id_ir_q[25:21];
  assign id_rt         = if_id_ir_q[20:16];
  assign mem_dst       = dest_of(ex_mem_ir_q);
  assign wb_dst        = dest_of(mem_wb_ir_q);
  assign ex_op         = id_ex_ir_q[31:26];
  assign imm_ex        = {{16{id_ex_ir_q[15]}}, id_ex_ir_q[15:0]};
  assign unused_ok     = ^{mem_wb_ir_q[25:21], mem_wb_ir_q[10:0]};

  assign TAKEN_BRANCH = ((ex_op == OP_BNEQZ) && (id_ex_a_q != 32'd0)) ||
                        ((ex_op == OP_BEQZ)  && (id_ex_a_q == 32'd0));

  always_comb begin
    ex_mem_alu_d = 32'd0;
    case (ex_op)
      OP_ADD:              ex_mem_alu_d = id_ex_a_q + id_ex_b_q;
      OP_SUB:              ex_mem_alu_d = id_ex_a_q - id_ex_b_q;
      OP_AND:              ex_mem_alu_d = id_ex_a_q & id_ex_b_q;
      OP_OR:               ex_mem_alu_d = id_ex_a_q | id_ex_b_q;
      OP_SLT:              ex_mem_alu_d = {31'd0, $signed(id_ex_a_q) < $signed(id_ex_b_q)};
      OP_MUL:              ex_mem_alu_d = id_ex_a_q * id_ex_b_q;
      OP_ADDI, OP_LW, OP_SW: ex_mem_alu_d = id_ex_a_q + imm_ex;
      OP_SUBI:             ex_mem_alu_d = id_ex_a_q - imm_ex;
      OP_SLTI:             ex_mem_alu_d = {31'd0, $signed(id_ex_a_q) < $signed(imm_ex)};
      default:             ex_mem_alu_d = 32'd0;
    endcase
  end

  // Fetch and ID capture; a taken branch overrides fetch and squashes both younger slots.
  always_comb begin
    pc_d         = PC;
    fetch_stop_d = fetch_stop_q;
    if_id_ir_d   = NOP_IR;
    if_id_npc_d  = if_id_npc_q;
    id_ex_ir_d   = if_id_ir_q;
    id_ex_npc_d  = if_id_npc_q;
    id_ex_a_d    = operand(id_rs, mem_dst, mem_stage_val, wb_dst, mem_wb_val_q, regfile[id_rs]);
    id_ex_b_d    = operand(id_rt, mem_dst, mem_stage_val, wb_dst, mem_wb_val_q, regfile[id_rt]);
    if (TAKEN_BRANCH) begin
      pc_d         = id_ex_npc_q + imm_ex[9:0];
      fetch_stop_d = 1'b0;
      id_ex_ir_d   = NOP_IR;
    end else if (!fetch_stop_q) begin
      if_id_ir_d  = fetch_ir;
      if_id_npc_d = PC + 10'd1;
      if (fetch_ir[31:26] == OP_HLT) fetch_stop_d = 1'b1;
      else                           pc_d = PC + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC           <= 10'd0;
      fetch_stop_q <= 1'b0;
      HALTED       <= 1'b0;
      if_id_ir_q   <= NOP_IR;
      if_id_npc_q  <= 10'd0;
      id_ex_ir_q   <= NOP_IR;
      id_ex_npc_q  <= 10'd0;
      id_ex_a_q    <= 32'd0;
      id_ex_b_q    <= 32'd0;
      ex_mem_ir_q  <= NOP_IR;
      ex_mem_alu_q <= 32'd0;
      ex_mem_b_q   <= 32'd0;
      mem_wb_ir_q  <= NOP_IR;
      mem_wb_val_q <= 32'd0;
    end else begin
      PC           <= pc_d;
      fetch_stop_q <= fetch_stop_d;
      HALTED       <= HALTED | (mem_wb_ir_q[31:26] == OP_HLT);
      if_id_ir_q   <= if_id_ir_d;
      if_id_npc_q  <= if_id_npc_d;
      id_ex_ir_q   <= id_ex_ir_d;
      id_ex_npc_q  <= id_ex_npc_d;
      id_ex_a_q    <= id_ex_a_d;
      id_ex_b_q    <= id_ex_b_d;
      ex_mem_ir_q  <= id_ex_ir_q;
      ex_mem_alu_q <= ex_mem_alu_d;
      ex_mem_b_q   <= id_ex_b_q;
      mem_wb_ir_q  <= ex_mem_ir_q;
      mem_wb_val_q <= mem_stage_val;
    end
  end

  // Pipeline registers reset to NOPs asynchronously, so no write can fire while rst is high.
  always_ff @(posedge clk) begin
    if (ex_mem_ir_q[31:26] == OP_SW) mem[ex_mem_alu_q[9:0]] <= ex_mem_b_q;
  end

  always_ff @(posedge clk) begin
    if (wb_dst != 5'd0) regfile[wb_dst] <= mem_wb_val_q;
  end

endmodule

// File: tb/tb_risc_processor.sv
// Directed programs with a result scoreboard for the risc_processor pipeline.
module tb_risc_processor;
  logic clk = 1'b0;
  logic rst = 1'b1;

  risc_processor dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101;
  localparam logic [5:0] OP_SW = 6'b001001, OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;
  localparam logic [31:0] NOP_W = 32'hF800_0000;
  localparam logic [31:0] HLT_W = 32'hFC00_0000;

  typedef struct {
    string       tag;
    bit          is_mem;
    logic [9:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic put(input logic [9:0] a, input logic [31:0] w);
    dut.mem[a] <= w;
  endtask

  task automatic exp_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
    sb.push_back('{tag, 1'b0, {5'd0, r}, v});
  endtask

  task automatic exp_mem(input string tag, input logic [9:0] a, input logic [31:0] v);
    sb.push_back('{tag, 1'b1, a, v});
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_mem) check(e.tag, dut.mem[e.addr], e.val);
      else          check(e.tag, dut.regfile[e.addr[4:0]], e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset, wipe low memory, preload regfile[k] = k and mem[120] = 85.
  task automatic start_test();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.mem[10'(i)] <= 32'd0;
    for (int k = 0; k < 32; k++) dut.regfile[5'(k)] <= 32'(k);
    dut.mem[10'd120] <= 32'd85;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_halt(input int max_cycles, output int n_taken);
    int n;
    n = 0;
    n_taken = 0;
    while (dut.HALTED !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
      if (dut.TAKEN_BRANCH === 1'b1) n_taken++;
    end
    check("halt_reached", 32'(dut.HALTED), 32'd1);
  endtask

  task automatic load_ref_prog();
    put(10'd0, 32'h28010078); put(10'd1, 32'h0c631800);
    put(10'd2, 32'h20220000); put(10'd3, 32'h0c631800);
    put(10'd4, 32'h2842002d); put(10'd5, 32'h0c631800);
    put(10'd6, 32'h24220001); put(10'd7, 32'hfc000000);
  endtask

  initial begin
    // Reference program with cycle-exact store and halt timing
    start_test();
    load_ref_prog();
    check("reset_pc", 32'(dut.PC), 32'd0);
    check("reset_halted", 32'(dut.HALTED), 32'd0);
    check("reset_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
    exp_reg("ref_r1", 5'd1, 32'd120);
    exp_reg("ref_r2", 5'd2, 32'd130);
    exp_mem("ref_m121", 10'd121, 32'd130);
    exp_mem("ref_m120", 10'd120, 32'd85);
    release_reset();
    tick(9);
    check("ref_m121_edge9", dut.mem[10'd121], 32'd0);
    tick(1);
    check("ref_m121_edge10", dut.mem[10'd121], 32'd130);
    tick(1);
    check("ref_halted_edge11", 32'(dut.HALTED), 32'd0);
    tick(1);
    check("ref_halted_edge12", 32'(dut.HALTED), 32'd1);
    drain_sb();

    // RR/RI ALU operations, including signed compares and a negative result
    start_test();
    put(10'd0, ri(OP_ADDI, 5'd1, 5'd0, 16'd7));
    put(10'd1, ri(OP_ADDI, 5'd2, 5'd0, 16'd3));
    put(10'd2, NOP_W);
    put(10'd3, rr(OP_ADD, 5'd10, 5'd1, 5'd2));
    put(10'd4, rr(OP_SUB, 5'd11, 5'd1, 5'd2));
    put(10'd5, rr(OP_AND, 5'd12, 5'd1, 5'd2));
    put(10'd6, rr(OP_OR,  5'd13, 5'd1, 5'd2));
    put(10'd7, rr(OP_MUL, 5'd14, 5'd1, 5'd2));
    put(10'd8, rr(OP_SLT, 5'd15, 5'd1, 5'd2));
    put(10'd9, ri(OP_SUBI, 5'd1, 5'd1, 16'd10));
    put(10'd10, NOP_W);
    put(10'd11, ri(OP_SLTI, 5'd16, 5'd1, 16'd0));
    put(10'd12, rr(OP_SLT, 5'd17, 5'd1, 5'd2));
    put(10'd13, HLT_W);
    exp_reg("alu_add", 5'd10, 32'd10);
    exp_reg("alu_sub", 5'd11, 32'd4);
    exp_reg("alu_and", 5'd12, 32'd3);
    exp_reg("alu_or",  5'd13, 32'd7);
    exp_reg("alu_mul", 5'd14, 32'd21);
    exp_reg("alu_slt", 5'd15, 32'd0);
    exp_reg("alu_subi", 5'd1, 32'hFFFF_FFFD);
    exp_reg("alu_slti", 5'd16, 32'd1);
    exp_reg("alu_slt_neg", 5'd17, 32'd1);
    release_reset();
    run_until_halt(200, taken);
    drain_sb();

    // 5! loop with BNEQZ; the two slots after the branch count their own executions
    start_test();
    put(10'd0, ri(OP_ADDI, 5'd3, 5'd0, 16'd1));
    put(10'd1, ri(OP_ADDI, 5'd4, 5'd0, 16'd5));
    put(10'd2, NOP_W);
    put(10'd3, rr(OP_MUL, 5'd3, 5'd3, 5'd4));
    put(10'd4, ri(OP_SUBI, 5'd4, 5'd4, 16'd1));
    put(10'd5, NOP_W);
    put(10'd6, ri(OP_BNEQZ, 5'd0, 5'd4, 16'hFFFC));
    put(10'd7, ri(OP_ADDI, 5'd20, 5'd20, 16'd1));
    put(10'd8, ri(OP_ADDI, 5'd21, 5'd21, 16'd1));
    put(10'd9, HLT_W);
    exp_reg("fact_r3", 5'd3, 32'd120);
    exp_reg("fact_r4", 5'd4, 32'd0);
    exp_reg("fact_shadow1", 5'd20, 32'd21);
    exp_reg("fact_shadow2", 5'd21, 32'd22);
    release_reset();
    run_until_halt(400, taken);
    check("fact_taken_count", 32'(taken), 32'd4);
    drain_sb();

    // R0 protection and a taken BEQZ on R0
    start_test();
    put(10'd0, ri(OP_ADDI, 5'd0, 5'd0, 16'd5));
    put(10'd1, NOP_W);
    put(10'd2, rr(OP_ADD, 5'd4, 5'd0, 5'd0));
    put(10'd3, ri(OP_BEQZ, 5'd0, 5'd0, 16'd2));
    put(10'd4, ri(OP_ADDI, 5'd22, 5'd0, 16'd1));
    put(10'd5, ri(OP_ADDI, 5'd23, 5'd0, 16'd1));
    put(10'd6, HLT_W);
    exp_reg("r0_add", 5'd4, 32'd0);
    exp_reg("r0_store", 5'd0, 32'd0);
    exp_reg("beqz_shadow1", 5'd22, 32'd22);
    exp_reg("beqz_shadow2", 5'd23, 32'd23);
    release_reset();
    run_until_halt(200, taken);
    check("beqz_taken_count", 32'(taken), 32'd1);
    drain_sb();

    // Reset while the SW is in ID, then rerun from the kept memory/regfile
    start_test();
    load_ref_prog();
    release_reset();
    tick(7);
    rst = 1'b1;
    #1;
    check("midrst_pc", 32'(dut.PC), 32'd0);
    check("midrst_halted", 32'(dut.HALTED), 32'd0);
    tick(3);
    check("midrst_m121", dut.mem[10'd121], 32'd0);
    check("midrst_r2_kept", dut.regfile[5'd2], 32'd85);
    check("midrst_r1_kept", dut.regfile[5'd1], 32'd120);
    exp_reg("rerun_r1", 5'd1, 32'd120);
    exp_reg("rerun_r2", 5'd2, 32'd130);
    exp_mem("rerun_m121", 10'd121, 32'd130);
    release_reset();
    run_until_halt(200, taken);
    drain_sb();

    // Halt drain: nothing after HLT may write, PC stays on the HLT
    start_test();
    dut.mem[10'd200] <= 32'h0000_DEAD;
    put(10'd0, ri(OP_ADDI, 5'd6, 5'd0, 16'd9));
    put(10'd1, HLT_W);
    put(10'd2, ri(OP_ADDI, 5'd5, 5'd0, 16'd1));
    put(10'd3, ri(OP_SW, 5'd6, 5'd0, 16'd200));
    exp_reg("drain_r6", 5'd6, 32'd9);
    exp_reg("drain_r5", 5'd5, 32'd5);
    exp_mem("drain_m200", 10'd200, 32'h0000_DEAD);
    release_reset();
    run_until_halt(200, taken);
    check("drain_pc_at_halt", 32'(dut.PC), 32'd1);
    tick(20);
    check("drain_pc_frozen", 32'(dut.PC), 32'd1);
    check("drain_halted_sticky", 32'(dut.HALTED), 32'd1);
    drain_sb();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
